// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared ALU function codes, FP constants and the issue-controller state type.
package fpu_issue_ctrl_pkg;

  localparam logic [4:0] ALU_ADD     = 5'h00;
  localparam logic [4:0] ALU_FMULS   = 5'h10;
  localparam logic [4:0] ALU_FADDS   = 5'h11;
  localparam logic [4:0] ALU_FSUBS   = 5'h12;
  localparam logic [4:0] ALU_FCVTSW  = 5'h13;
  localparam logic [4:0] ALU_FCVTSWU = 5'h14;
  localparam logic [4:0] ALU_FCVTWS  = 5'h15;
  localparam logic [4:0] ALU_FCVTWUS = 5'h16;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUBBLE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } fpu_ctrl_state_t;

  function automatic logic is_multi_op(input logic [4:0] func);
    return (func == ALU_FMULS) || (func == ALU_FADDS) || (func == ALU_FSUBS);
  endfunction

  function automatic logic is_single_op(input logic [4:0] func);
    return (func == ALU_FCVTSW) || (func == ALU_FCVTSWU) ||
           (func == ALU_FCVTWS) || (func == ALU_FCVTWUS);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// ID/EX request, stall and result handshake between the pipeline and the FPU issue controller.
interface fpu_issue_ctrl_if;
  logic        req_valid;
  logic [4:0]  req_func;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic [2:0]  req_rm;
  logic        flush;
  logic        req_ready;
  logic        ex_stall;
  logic        res_valid;
  logic [31:0] res_data;

  modport master (
    output req_valid, req_func, req_opa, req_opb, req_rm, flush,
    input  req_ready, ex_stall, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_func, req_opa, req_opb, req_rm, flush,
    output req_ready, ex_stall, res_valid, res_data
  );
endinterface

// File: rtl/fpu_busy_watchdog.sv
// Counts WAIT cycles while the FPU is busy; flags a sticky error once TIMEOUT_CYC is reached.
module fpu_busy_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic busy_i,
  output logic expire_o,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Expires in the TIMEOUT_CYC-th consecutive WAIT cycle that still sees busy.
  assign expire_o = run_i && busy_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = run_i ? (cnt_q + CNT_W'(1)) : '0;
    err_d = err_q || expire_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Requester-side sequencer for the EX-stage FPU: issues ops, holds inputs while busy, returns results.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_issue_ctrl_if.slave      req_if,
  output logic [31:0]          fpu_opa_o,
  output logic [31:0]          fpu_opb_o,
  output logic [4:0]           fpu_func_o,
  output logic [2:0]           fpu_rm_o,
  input  logic [31:0]          fpu_res_i,
  input  logic                 fpu_busy_i,
  output logic                 err_timeout_o
);
  import fpu_issue_ctrl_pkg::*;

  fpu_ctrl_state_t state_q, state_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]  func_q, func_d;
  logic [2:0]  rm_q, rm_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [4:0]  last_func_q, last_func_d;
  logic [31:0] last_opa_q, last_opa_d, last_opb_q, last_opb_d;
  logic        last_valid_q, last_valid_d;
  logic        req_multi, req_single, single_go, repeat_op;
  logic        wd_run, wd_expire;

  assign req_multi  = req_if.req_valid && !req_if.flush && is_multi_op(req_if.req_func);
  assign req_single = req_if.req_valid && !req_if.flush && is_single_op(req_if.req_func);
  assign single_go  = (state_q == ST_IDLE) && req_single;
  assign repeat_op  = last_valid_q &&
    ({req_if.req_func, req_if.req_opa, req_if.req_opb} == {last_func_q, last_opa_q, last_opb_q});
  assign wd_run     = (state_q == ST_WAIT) && !req_if.flush;

  fpu_busy_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (wd_run),
    .busy_i   (fpu_busy_i),
    .expire_o (wd_expire),
    .err_o    (err_timeout_o)
  );

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    func_d       = func_q;
    rm_d         = rm_q;
    res_data_d   = res_data_q;
    res_valid_d  = 1'b0;
    last_func_d  = last_func_q;
    last_opa_d   = last_opa_q;
    last_opb_d   = last_opb_q;
    last_valid_d = last_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (single_go) begin
          res_data_d  = fpu_res_i;
          res_valid_d = 1'b1;
        end else if (req_multi) begin
          rm_d = req_if.req_rm;
          if (repeat_op) begin
            // Identical repeat: park a non-FP func for one cycle so the FPU sees a change.
            func_d  = ALU_ADD;
            state_d = ST_BUBBLE;
          end else begin
            opa_d   = req_if.req_opa;
            opb_d   = req_if.req_opb;
            func_d  = req_if.req_func;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_BUBBLE, ST_ISSUE, ST_WAIT: begin
        if (req_if.flush) begin
          func_d       = ALU_ADD;
          last_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (state_q == ST_BUBBLE) begin
          // Bubble is only entered on an exact repeat, so the last-issued copy is the op.
          opa_d   = last_opa_q;
          opb_d   = last_opb_q;
          func_d  = last_func_q;
          state_d = ST_ISSUE;
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
        end else if (!fpu_busy_i) begin
          res_data_d   = fpu_res_i;
          res_valid_d  = 1'b1;
          last_func_d  = func_q;
          last_opa_d   = opa_q;
          last_opb_d   = opb_q;
          last_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else if (wd_expire) begin
          res_data_d  = FP_CANON_NAN;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      func_q       <= ALU_ADD;
      rm_q         <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      last_func_q  <= '0;
      last_opa_q   <= '0;
      last_opb_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      func_q       <= func_d;
      rm_q         <= rm_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      last_func_q  <= last_func_d;
      last_opa_q   <= last_opa_d;
      last_opb_q   <= last_opb_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign req_if.req_ready = single_go || (state_q == ST_DONE);
  assign req_if.ex_stall  = ((state_q == ST_IDLE) && req_multi) ||
                            (state_q == ST_BUBBLE) || (state_q == ST_ISSUE) ||
                            (state_q == ST_WAIT);
  assign req_if.res_valid = res_valid_q;
  assign req_if.res_data  = res_data_q;

  assign fpu_opa_o  = single_go ? req_if.req_opa  : opa_q;
  assign fpu_opb_o  = single_go ? req_if.req_opb  : opb_q;
  assign fpu_func_o = single_go ? req_if.req_func : func_q;
  assign fpu_rm_o   = single_go ? req_if.req_rm   : rm_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: FPU stub with programmable busy, transaction-level reference.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fpu_opa, fpu_opb, fpu_res;
  logic [4:0]  fpu_func;
  logic [2:0]  fpu_rm;
  logic        fpu_busy, err_to;

  fpu_issue_ctrl_if ifc ();

  fpu_issue_ctrl #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_if        (ifc),
    .fpu_opa_o     (fpu_opa),
    .fpu_opb_o     (fpu_opb),
    .fpu_func_o    (fpu_func),
    .fpu_rm_o      (fpu_rm),
    .fpu_res_i     (fpu_res),
    .fpu_busy_i    (fpu_busy),
    .err_timeout_o (err_to)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic bit ref_multi(input logic [4:0] f);
    case (f)
      ALU_FMULS, ALU_FADDS, ALU_FSUBS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_single(input logic [4:0] f);
    case (f)
      ALU_FCVTSW, ALU_FCVTSWU, ALU_FCVTWS, ALU_FCVTWUS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Stand-in FPU arithmetic: a few exact IEEE cases, otherwise a mixing hash of all inputs.
  function automatic logic [31:0] ref_result(input logic [4:0] f, input logic [31:0] a,
                                             input logic [31:0] b, input logic [2:0] rm);
    if (f == ALU_FMULS && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    if (f == ALU_FADDS && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (f == ALU_FCVTSW && a == 32'h00000005) return 32'h40A00000;
    return a ^ {b[15:0], b[31:16]} ^ {rm, 24'd0, f};
  endfunction

  // FPU stub: a new multi-cycle input raises busy for blat cycles; stuck forces busy.
  int unsigned blat = 0;
  bit          stuck = 1'b0;
  int unsigned fpu_rem = 0;
  logic [68:0] fpu_prev = '0;

  assign fpu_res  = ref_result(fpu_func, fpu_opa, fpu_opb, fpu_rm);
  assign fpu_busy = stuck || (fpu_rem != 0);

  always @(posedge clk) begin
    if ({fpu_func, fpu_opa, fpu_opb} !== fpu_prev)
      fpu_rem <= ref_multi(fpu_func) ? blat : 0;
    else if (fpu_rem != 0)
      fpu_rem <= fpu_rem - 1;
    fpu_prev <= {fpu_func, fpu_opa, fpu_opb};
  end

  // Per-cycle observations of the most recent run_op.
  bit          s_stall [128];
  bit          s_ready [128];
  bit          s_err   [128];
  logic [4:0]  s_func  [128];
  logic [31:0] s_opa   [128];
  logic [31:0] s_opb   [128];
  logic [2:0]  s_rm    [128];
  logic [31:0] s_rd    [128];
  int          res_k, res_cnt, n_cyc;
  logic [107:0] snap;
  localparam logic [107:0] RST_VEC = {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ALU_ADD, 3'b0, 1'b0};

  // Reference model state: last multi-cycle op that completed normally.
  logic [68:0] m_last_key = '0;
  bit          m_last_ok = 1'b0;

  logic [4:0] codes [9] = '{ALU_FMULS, ALU_FADDS, ALU_FSUBS, ALU_FCVTSW, ALU_FCVTSWU,
                            ALU_FCVTWS, ALU_FCVTWUS, ALU_ADD, 5'h1F};

  // Presents one request and records outputs each cycle; starts and ends 1ns after a posedge.
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input int flush_k, input int rst_k,
                        input int limit, input bit scramble);
    ifc.req_valid = 1'b1; ifc.req_func = f; ifc.req_opa = a; ifc.req_opb = b; ifc.req_rm = rm;
    ifc.flush = 1'b0;
    res_k = -1; res_cnt = 0; n_cyc = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      s_stall[k] = ifc.ex_stall; s_ready[k] = ifc.req_ready; s_err[k] = err_to;
      s_func[k] = fpu_func; s_opa[k] = fpu_opa; s_opb[k] = fpu_opb; s_rm[k] = fpu_rm;
      s_rd[k] = ifc.res_data;
      if (ifc.res_valid) begin
        if (res_cnt == 0) res_k = k;
        res_cnt++;
      end
      n_cyc = k + 1;
      @(posedge clk); #1;
      if (s_ready[k]) ifc.req_valid = 1'b0;
      if (scramble && ifc.req_valid) begin
        ifc.req_opa = $urandom; ifc.req_opb = $urandom; ifc.req_rm = 3'($urandom);
      end
      ifc.flush = (k + 1 == flush_k);
      if (ifc.flush) ifc.req_valid = 1'b0;
      if (k + 1 == rst_k) begin
        #2; rst_n = 1'b0; ifc.req_valid = 1'b0;
        #1; snap = {ifc.res_valid, ifc.res_data, ifc.req_ready, ifc.ex_stall,
                    fpu_opa, fpu_opb, fpu_func, fpu_rm, err_to};
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      if (res_k >= 0 && k >= res_k + 1) break;
    end
    ifc.req_valid = 1'b0; ifc.flush = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.req_valid = 1'b0; ifc.req_func = '0; ifc.req_opa = '0; ifc.req_opb = '0;
    ifc.req_rm = '0; ifc.flush = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.res_valid, ifc.res_data, ifc.req_ready, ifc.ex_stall, fpu_opa, fpu_opb,
         fpu_func, fpu_rm, err_to} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", {ifc.res_valid, ifc.res_data, ifc.req_ready,
               ifc.ex_stall, fpu_opa, fpu_opb, fpu_func, fpu_rm, err_to}, RST_VEC);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    m_last_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fcvt();
    int bad;
    blat = 0;
    run_op(ALU_FCVTSW, 32'h5, 32'h0, 3'd0, -1, -1, 20, 1'b0);
    checks++; if (res_k !== 1) begin errors++; $display("FAIL fcvt_latency got %0d want 1", res_k); end
    checks++; if (res_cnt !== 1) begin errors++; $display("FAIL fcvt_count got %0d want 1", res_cnt); end
    checks++; if (s_rd[1] !== 32'h40A00000) begin errors++; $display("FAIL fcvt_data got %h want 40a00000", s_rd[1]); end
    bad = 0;
    for (int k = 0; k < n_cyc; k++) if (s_stall[k] || (s_ready[k] !== (k == 0))) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL fcvt_stall_ready got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_fmuls();
    int bs, bh;
    blat = 2;
    run_op(ALU_FMULS, 32'h3FC00000, 32'h40000000, 3'd1, -1, -1, 40, 1'b1);
    checks++; if (res_k !== 5) begin errors++; $display("FAIL fmuls_latency got %0d want 5", res_k); end
    checks++; if (res_cnt !== 1) begin errors++; $display("FAIL fmuls_count got %0d want 1", res_cnt); end
    checks++; if (s_rd[5] !== 32'h40400000) begin errors++; $display("FAIL fmuls_data got %h want 40400000", s_rd[5]); end
    bs = 0; bh = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (s_stall[k] !== (k < 5) || s_ready[k] !== (k == 5)) bs++;
      if (k >= 1 && k <= 5 && {s_func[k], s_opa[k], s_opb[k], s_rm[k]} !==
          {ALU_FMULS, 32'h3FC00000, 32'h40000000, 3'd1}) bh++;
    end
    checks++; if (bs !== 0) begin errors++; $display("FAIL fmuls_stall_ready got %0d bad cycles want 0", bs); end
    checks++; if (bh !== 0) begin errors++; $display("FAIL fmuls_hold got %0d bad cycles want 0", bh); end
    m_last_key = {ALU_FMULS, 32'h3FC00000, 32'h40000000}; m_last_ok = 1'b1;
  endtask

  task automatic test_back_to_back();
    blat = 1;
    for (int i = 0; i < 2; i++) begin
      run_op(ALU_FADDS, 32'h3F800000, 32'h3F800000, 3'd0, -1, -1, 40, 1'b1);
      checks++;
      if (res_k !== 4 + i) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, res_k, 4 + i); end
      checks++;
      if (s_rd[4+i] !== 32'h40000000) begin errors++; $display("FAIL b2b_data[%0d] got %h want 40000000", i, s_rd[4+i]); end
      checks++;
      if (s_func[1] !== (i == 1 ? ALU_ADD : ALU_FADDS))
        begin errors++; $display("FAIL b2b_func_c1[%0d] got %h want %h", i, s_func[1], (i == 1 ? ALU_ADD : ALU_FADDS)); end
    end
    m_last_key = {ALU_FADDS, 32'h3F800000, 32'h3F800000}; m_last_ok = 1'b1;
  endtask

  task automatic test_flush();
    blat = 1;
    run_op(ALU_FMULS, 32'h3FC00000, 32'h40000000, 3'd2, -1, -1, 40, 1'b0);
    checks++; if (res_k !== 4) begin errors++; $display("FAIL flush_pre_latency got %0d want 4", res_k); end
    blat = 5;
    run_op(ALU_FMULS, 32'h3FC00000, 32'h40000000, 3'd2, 4, -1, 12, 1'b0);
    checks++; if (res_cnt !== 0) begin errors++; $display("FAIL flush_no_result got %0d want 0", res_cnt); end
    checks++; if (s_func[1] !== ALU_ADD) begin errors++; $display("FAIL flush_bubble_func got %h want %h", s_func[1], ALU_ADD); end
    checks++;
    if ({s_stall[5], s_func[5]} !== {1'b0, ALU_ADD})
      begin errors++; $display("FAIL flush_idle got stall=%0d func=%h want stall=0 func=%h", s_stall[5], s_func[5], ALU_ADD); end
    m_last_ok = 1'b0;
    blat = 2;
    run_op(ALU_FMULS, 32'h3FC00000, 32'h40000000, 3'd2, -1, -1, 40, 1'b0);
    checks++; if (s_func[1] !== ALU_FMULS) begin errors++; $display("FAIL flush_reissue_func got %h want %h", s_func[1], ALU_FMULS); end
    checks++; if (res_k !== 5) begin errors++; $display("FAIL flush_reissue_latency got %0d want 5", res_k); end
    m_last_key = {ALU_FMULS, 32'h3FC00000, 32'h40000000}; m_last_ok = 1'b1;
  endtask

  task automatic test_timeout();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    stuck = 1'b1;
    run_op(ALU_FSUBS, a, b, 3'd3, -1, -1, 96, 1'b1);
    stuck = 1'b0;
    checks++; if (res_k !== 66) begin errors++; $display("FAIL timeout_latency got %0d want 66", res_k); end
    checks++; if (s_rd[66] !== 32'h7FC00000) begin errors++; $display("FAIL timeout_data got %h want 7fc00000", s_rd[66]); end
    checks++;
    if ({s_err[0], s_err[65], s_err[66], s_err[67]} !== 4'b0011)
      begin errors++; $display("FAIL timeout_err got %b want 0011", {s_err[0], s_err[65], s_err[66], s_err[67]}); end
  endtask

  task automatic test_reset_mid();
    blat = 10;
    run_op(ALU_FADDS, 32'h3F800000, 32'h3F800000, 3'd0, -1, 4, 10, 1'b0);
    checks++; if (snap !== RST_VEC) begin errors++; $display("FAIL rstmid_async got %h want %h", snap, RST_VEC); end
    checks++; if (res_cnt !== 0) begin errors++; $display("FAIL rstmid_no_result got %0d want 0", res_cnt); end
    m_last_ok = 1'b0;
    blat = 1;
    run_op(ALU_FADDS, 32'h3F800000, 32'h3F800000, 3'd0, -1, -1, 40, 1'b0);
    checks++;
    if ({res_k, s_rd[4], s_func[1]} !== {32'sd4, 32'h40000000, ALU_FADDS})
      begin errors++; $display("FAIL rstmid_clean got k=%0d data=%h func=%h want k=4 data=40000000 func=%h", res_k, s_rd[4], s_func[1], ALU_FADDS); end
    m_last_key = {ALU_FADDS, 32'h3F800000, 32'h3F800000}; m_last_ok = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] f; logic [31:0] a, b; logic [2:0] rm;
    bit mul, sgl, bub; int exp_k, exp_cnt, bs, bh;
    for (int i = 0; i < 40; i++) begin
      f = codes[$urandom_range(0, 8)];
      a = $urandom; b = $urandom;
      if (ref_multi(f) && m_last_ok && $urandom_range(0, 2) == 0) {f, a, b} = m_last_key;
      rm = 3'($urandom_range(0, 7));
      blat = $urandom_range(0, 4);
      mul = ref_multi(f); sgl = ref_single(f);
      bub = mul && m_last_ok && ({f, a, b} == m_last_key);
      exp_k = mul ? int'(blat) + 3 + int'(bub) : (sgl ? 1 : -1);
      exp_cnt = (mul || sgl) ? 1 : 0;
      run_op(f, a, b, rm, -1, -1, (mul || sgl) ? 40 : 3, mul);
      checks++;
      if (res_cnt !== exp_cnt || res_k !== exp_k)
        begin errors++; $display("FAIL rand[%0d] f=%h timing got cnt=%0d k=%0d want cnt=%0d k=%0d", i, f, res_cnt, res_k, exp_cnt, exp_k); end
      if (exp_cnt == 1) begin
        checks++;
        if (s_rd[exp_k] !== ref_result(f, a, b, rm))
          begin errors++; $display("FAIL rand[%0d] data got %h want %h", i, s_rd[exp_k], ref_result(f, a, b, rm)); end
      end
      bs = 0; bh = 0;
      for (int k = 0; k < n_cyc; k++) begin
        if (s_stall[k] !== (mul && k < exp_k)) bs++;
        if (s_ready[k] !== ((mul && k == exp_k) || (sgl && k == 0))) bs++;
        if (mul && k >= 1 + int'(bub) && k <= exp_k && {s_func[k], s_opa[k], s_opb[k], s_rm[k]} !== {f, a, b, rm}) bh++;
      end
      if (mul && s_func[1] !== (bub ? ALU_ADD : f)) bh++;
      checks++; if (bs !== 0) begin errors++; $display("FAIL rand[%0d] stall_ready got %0d bad want 0", i, bs); end
      checks++; if (bh !== 0) begin errors++; $display("FAIL rand[%0d] fpu_inputs got %0d bad want 0", i, bh); end
      if (mul) begin m_last_key = {f, a, b}; m_last_ok = 1'b1; end
    end
  endtask

  initial begin
    test_reset();
    test_fcvt();
    test_fmuls();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached at %0t want completion earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Requester-side sequencer for the EX-stage FPU.
- Accepts one FP operation per handshake from ID/EX and drives the FPU operand, function and rounding-mode inputs.
- Holds those inputs stable while the FPU reports busy, captures the rounded result, and returns it with a valid strobe. It also stalls the pipeline.
- Guarantees the FPU sees an input change on every new issue, so back-to-back identical operations restart correctly.

Parameters:
- TIMEOUT_CYC, 64, busy cycles tolerated before err_timeout asserts.
- CNT_W, 7, width of the busy watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  ID/EX presents an FP op.
- req_func  in  5  ALU function code (`ALU_FMULS/FADDS/FSUBS/FCVTSW/FCVTSWU/FCVTWS/FCVTWUS).
- req_opa  in  32  operand A.
- req_opb  in  32  operand B.
- req_rm  in  3  rounding mode.
- flush  in  1  squash the in-flight op.
- req_ready  out  1  op accepted this cycle.
- ex_stall  out  1  hold the upstream pipeline.
- fpu_opa  out  32  to FPU.
- fpu_opb  out  32  to FPU.
- fpu_func  out  5  to FPU.
- fpu_rm  out  3  to FPU.
- fpu_res  in  32  FPU result (combinational).
- fpu_busy  in  1  FPU busy (combinational on func/operands).
- res_valid  out  1  one-cycle result strobe.
- res_data  out  32  captured result.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (rst_n low, async) drives all outputs and registers to their idle values:
  - state=IDLE.
  - fpu_opa=fpu_opb=0, fpu_func=`ALU_ADD (non-FP), fpu_rm=0.
  - res_valid=0, res_data=0, req_ready=0, ex_stall=0, err_timeout=0, watchdog counter=0.
  - last-issued register {func,opa,opb}=0, last_valid=0.
- Multi-cycle ops: FMULS, FADDS, FSUBS. Single-cycle ops: the four FCVT codes.
- Any other req_func is not accepted and is ignored (req_ready=0, no state change).
- FSM states: IDLE, BUBBLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_valid and the op is a single-cycle op: drive the FPU inputs combinationally from req_*, assert req_ready, register res_data<=fpu_res, res_valid=1 next cycle. State stays IDLE. Latency is 1 cycle; no stall.
  - If req_valid and the op is a multi-cycle op whose {func,opa,opb} equals the last-issued value with last_valid=1: go to BUBBLE, with ex_stall=1.
  - Otherwise, for a multi-cycle op: latch req_* into the FPU output registers, then go to ISSUE, with ex_stall=1.
- BUBBLE:
  - Drive fpu_func=`ALU_ADD for exactly 1 cycle so the FPU detects new input.
  - Then latch the op, go to ISSUE.
- ISSUE:
  - FPU inputs are registered and stable; ex_stall=1.
  - Next state is WAIT unconditionally (gives the FPU one cycle to raise busy).
- WAIT:
  - ex_stall=1; the watchdog increments each cycle.
  - When fpu_busy=0: capture res_data<=fpu_res, update the last-issued register, go to DONE.
  - When the counter reaches TIMEOUT_CYC: set err_timeout=1 (sticky until reset), capture res_data=32'h7FC00000 (canonical NaN), go to DONE.
- DONE:
  - res_valid=1 and req_ready=1 for one cycle; ex_stall=0.
  - Next state is IDLE. The counter clears.
  - Next issue is accepted no earlier than the following cycle.
- FPU inputs are held bit-stable from ISSUE through DONE, irrespective of changes on req_*.
- flush:
  - In ISSUE/WAIT/BUBBLE: go to IDLE next cycle, no res_valid, drive fpu_func=`ALU_ADD, clear last_valid.
  - In DONE: res_valid still fires.
  - flush with req_valid in IDLE: the request is dropped.
- Minimum multi-cycle latency: 3 cycles from acceptance to res_valid (ISSUE, WAIT, DONE), +1 with BUBBLE.
- Reset asserted mid-operation: immediate return to reset values; no res_valid is emitted.

Decomposition:
- ALU function codes and the canonical-NaN constant come from the shared sys_defs.vh definitions.
- Add an fpu_ctrl_state_t enum to the shared package.
- One sub-module, fpu_busy_watchdog: counter, compare against TIMEOUT_CYC, sticky err flag.

Test Plan:
- FMULS, opa=0x3FC00000, opb=0x40000000, busy high 2 cycles -> ex_stall high until DONE; res_data=0x40400000, res_valid exactly once.
- FCVTSW, opa=0x00000005 -> res_valid next cycle, res_data=0x40A00000, ex_stall never asserted.
- Two back-to-back FADDS, opa=opb=0x3F800000 -> BUBBLE cycle shows fpu_func=`ALU_ADD; both results 0x40000000.
- FSUBS with fpu_busy stuck high -> err_timeout=1 after TIMEOUT_CYC WAIT cycles, res_data=0x7FC00000.
- Flush asserted in WAIT of FMULS -> no res_valid, IDLE next cycle; next identical FMULS issues without BUBBLE.
- rst_n pulled low during WAIT -> all outputs at reset values asynchronously; clean FADDS afterward completes.
